// File: rtl/fpu_wb_pkg.sv
// Shared definitions for the FP result write-back stage: function codes,
// the idle ALU code, the NaN-box pattern and the FSM state encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
package fpu_wb_pkg;

  localparam logic [4:0] FUNC_FMADD   = 5'd0;
  localparam logic [4:0] FUNC_FNMADD  = 5'd1;
  localparam logic [4:0] FUNC_FMSUB   = 5'd2;
  localparam logic [4:0] FUNC_FNMSUB  = 5'd3;
  localparam logic [4:0] FUNC_ADD     = 5'd4;
  localparam logic [4:0] FUNC_SUB     = 5'd5;
  localparam logic [4:0] FUNC_MUL     = 5'd6;
  localparam logic [4:0] FUNC_DIV     = 5'd7;
  localparam logic [4:0] FUNC_FSQRT   = 5'd8;
  localparam logic [4:0] FUNC_FSGNJ   = 5'd9;
  localparam logic [4:0] FUNC_FSGNJN  = 5'd10;
  localparam logic [4:0] FUNC_FSGNJX  = 5'd11;
  localparam logic [4:0] FUNC_MIN_MAX = 5'd12;
  localparam logic [4:0] FUNC_CLASS   = 5'd13;
  localparam logic [4:0] FUNC_FMV_X_W = 5'd14;
  localparam logic [4:0] FUNC_FMV_W_X = 5'd15;

  // Code that enables no ALU unit.
  localparam logic [4:0] FUNC_NOP = 5'h1F;

  // Upper half of a NaN-boxed single-precision value.
  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/fpu_result_writeback_if.sv
// Bundles the issue, ALU and write-back signals of the FP result write-back stage.
// Latency: n/a (wiring only). Backpressure: wb_ready stalls the stage, issue_ready reflects it.
// Modports: slave = the write-back stage, master = the issuer/ALU/register-file side.
interface fpu_result_writeback_if #(
  parameter int OP_DATA_WIDTH = 32
);
  // issue side
  logic                     issue_valid;
  logic                     issue_ready;
  logic [4:0]               issue_func;
  logic [4:0]               issue_rd;
  // ALU side
  logic [4:0]               alu_func;
  logic [OP_DATA_WIDTH-1:0] in_fp_fmadd;
  logic [OP_DATA_WIDTH-1:0] in_fp_fnmadd;
  logic [OP_DATA_WIDTH-1:0] in_fp_fmsub;
  logic [OP_DATA_WIDTH-1:0] in_fp_fnmsub;
  logic [OP_DATA_WIDTH-1:0] in_fp_add;
  logic [OP_DATA_WIDTH-1:0] in_fp_sub;
  logic [OP_DATA_WIDTH-1:0] in_fp_mul;
  logic [OP_DATA_WIDTH-1:0] in_fp_div;
  logic [OP_DATA_WIDTH-1:0] in_fp_sqrt;
  logic [OP_DATA_WIDTH-1:0] in_fp_fsgnj;
  logic [OP_DATA_WIDTH-1:0] in_fp_fsgnjn;
  logic [OP_DATA_WIDTH-1:0] in_fp_fsgnjx;
  logic [OP_DATA_WIDTH-1:0] in_fp_min_max;
  logic [OP_DATA_WIDTH-1:0] in_fp_fmv_w_x;
  logic [9:0]               in_class;
  logic [63:0]              in_fmv_x_w;
  // write-back side
  logic                     wb_valid;
  logic                     wb_ready;
  logic [63:0]              wb_data;
  logic [4:0]               wb_rd;
  logic                     wb_is_int;
  logic                     wb_illegal;
  logic                     busy;

  modport slave (
    input  issue_valid, issue_func, issue_rd,
    output issue_ready, alu_func,
    input  in_fp_fmadd, in_fp_fnmadd, in_fp_fmsub, in_fp_fnmsub, in_fp_add,
           in_fp_sub, in_fp_mul, in_fp_div, in_fp_sqrt, in_fp_fsgnj, in_fp_fsgnjn,
           in_fp_fsgnjx, in_fp_min_max, in_fp_fmv_w_x, in_class, in_fmv_x_w,
    input  wb_ready,
    output wb_valid, wb_data, wb_rd, wb_is_int, wb_illegal, busy
  );

  modport master (
    output issue_valid, issue_func, issue_rd,
    input  issue_ready, alu_func,
    output in_fp_fmadd, in_fp_fnmadd, in_fp_fmsub, in_fp_fnmsub, in_fp_add,
           in_fp_sub, in_fp_mul, in_fp_div, in_fp_sqrt, in_fp_fsgnj, in_fp_fsgnjn,
           in_fp_fsgnjx, in_fp_min_max, in_fp_fmv_w_x, in_class, in_fmv_x_w,
    output wb_ready,
    input  wb_valid, wb_data, wb_rd, wb_is_int, wb_illegal, busy
  );

endinterface

// File: rtl/fpu_wb_lat_lut.sv
// Maps an ALU function code to {legal, result latency, integer-destination flag}.
// Latency: purely combinational. Backpressure: none.
// Ports: i_func (code in), o_legal, o_lat (1..15 cycles), o_is_int.
module fpu_wb_lat_lut
  import fpu_wb_pkg::*;
#(
  parameter int LAT_ARITH = 1,
  parameter int LAT_DIV   = 4,
  parameter int LAT_SQRT  = 4,
  parameter int LAT_MISC  = 1
) (
  input  logic [4:0] i_func,
  output logic       o_legal,
  output logic [3:0] o_lat,
  output logic       o_is_int
);

  localparam logic [3:0] L_ARITH = 4'(LAT_ARITH);
  localparam logic [3:0] L_DIV   = 4'(LAT_DIV);
  localparam logic [3:0] L_SQRT  = 4'(LAT_SQRT);
  localparam logic [3:0] L_MISC  = 4'(LAT_MISC);

  always_comb begin
    o_legal  = 1'b0;
    o_lat    = 4'd1;
    o_is_int = 1'b0;
    case (i_func)
      FUNC_FMADD, FUNC_FNMADD, FUNC_FMSUB, FUNC_FNMSUB,
      FUNC_ADD, FUNC_SUB, FUNC_MUL: begin
        o_legal = 1'b1;
        o_lat   = L_ARITH;
      end
      FUNC_DIV: begin
        o_legal = 1'b1;
        o_lat   = L_DIV;
      end
      FUNC_FSQRT: begin
        o_legal = 1'b1;
        o_lat   = L_SQRT;
      end
      FUNC_FSGNJ, FUNC_FSGNJN, FUNC_FSGNJX, FUNC_MIN_MAX, FUNC_FMV_W_X: begin
        o_legal = 1'b1;
        o_lat   = L_MISC;
      end
      FUNC_CLASS, FUNC_FMV_X_W: begin
        o_legal  = 1'b1;
        o_lat    = L_MISC;
        o_is_int = 1'b1;
      end
      default: begin
        o_legal = 1'b0;
        o_lat   = 4'd1;
      end
    endcase
  end

endmodule

// File: rtl/fpu_result_writeback.sv
// Issues one FP op to the ALU, waits its fixed latency, formats the result to 64 bits.
// Latency: wb_valid is sampled high LAT+1 edges after the issue edge; one op per LAT+1 cycles.
// Backpressure: result held stable in HOLD until wb_ready; issue_ready low while busy.
// Ports: CLK, RST (sync, active high), bus = issue/ALU/write-back signals (slave modport).
module fpu_result_writeback
  import fpu_wb_pkg::*;
#(
  parameter int OP_DATA_WIDTH = 32,
  parameter int LAT_ARITH     = 1,
  parameter int LAT_DIV       = 4,
  parameter int LAT_SQRT      = 4,
  parameter int LAT_MISC      = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  fpu_result_writeback_if.slave  bus
);

  state_t                   r_state, w_state_nxt;
  logic [3:0]               r_cnt, w_cnt_nxt;
  logic [4:0]               r_func, w_func_nxt;
  logic [4:0]               r_rd, w_rd_nxt;
  logic                     r_is_int, w_is_int_nxt;
  logic [63:0]              r_wb_data, w_wb_data_nxt;
  logic [4:0]               r_wb_rd, w_wb_rd_nxt;
  logic                     r_wb_is_int, w_wb_is_int_nxt;
  logic                     r_wb_illegal, w_wb_illegal_nxt;

  logic                     w_legal;
  logic [3:0]               w_lat;
  logic                     w_is_int;
  logic                     w_issue_ready;
  logic                     w_fire;
  logic [OP_DATA_WIDTH-1:0] w_res;
  logic [63:0]              w_capture_dat;

  fpu_wb_lat_lut #(
    .LAT_ARITH (LAT_ARITH),
    .LAT_DIV   (LAT_DIV),
    .LAT_SQRT  (LAT_SQRT),
    .LAT_MISC  (LAT_MISC)
  ) u_lat_lut (
    .i_func   (bus.issue_func),
    .o_legal  (w_legal),
    .o_lat    (w_lat),
    .o_is_int (w_is_int)
  );

  // Retire and re-issue may happen in the same HOLD cycle, so there is no bubble.
  assign w_issue_ready   = (r_state == IDLE) | ((r_state == HOLD) & bus.wb_ready);
  assign w_fire          = bus.issue_valid & w_issue_ready;
  assign bus.issue_ready = w_issue_ready;
  // The ALU only sees a real code in the cycle the op is handed over.
  assign bus.alu_func    = (w_fire & ~RST) ? bus.issue_func : FUNC_NOP;

  assign bus.wb_valid    = (r_state == HOLD);
  assign bus.busy        = (r_state != IDLE);
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_is_int   = r_wb_is_int;
  assign bus.wb_illegal  = r_wb_illegal;

  // Result select and formatting for the op in flight.
  always_comb begin
    w_res = '0;
    case (r_func)
      FUNC_FMADD:   w_res = bus.in_fp_fmadd;
      FUNC_FNMADD:  w_res = bus.in_fp_fnmadd;
      FUNC_FMSUB:   w_res = bus.in_fp_fmsub;
      FUNC_FNMSUB:  w_res = bus.in_fp_fnmsub;
      FUNC_ADD:     w_res = bus.in_fp_add;
      FUNC_SUB:     w_res = bus.in_fp_sub;
      FUNC_MUL:     w_res = bus.in_fp_mul;
      FUNC_DIV:     w_res = bus.in_fp_div;
      FUNC_FSQRT:   w_res = bus.in_fp_sqrt;
      FUNC_FSGNJ:   w_res = bus.in_fp_fsgnj;
      FUNC_FSGNJN:  w_res = bus.in_fp_fsgnjn;
      FUNC_FSGNJX:  w_res = bus.in_fp_fsgnjx;
      FUNC_MIN_MAX: w_res = bus.in_fp_min_max;
      FUNC_FMV_W_X: w_res = bus.in_fp_fmv_w_x;
      default:      w_res = '0;
    endcase
    w_capture_dat = {NANBOX_HI, w_res[31:0]};
    if (r_func == FUNC_CLASS) begin
      w_capture_dat = {54'd0, bus.in_class};
    end else if (r_func == FUNC_FMV_X_W) begin
      w_capture_dat = bus.in_fmv_x_w;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_func_nxt       = r_func;
    w_rd_nxt         = r_rd;
    w_is_int_nxt     = r_is_int;
    w_wb_data_nxt    = r_wb_data;
    w_wb_rd_nxt      = r_wb_rd;
    w_wb_is_int_nxt  = r_wb_is_int;
    w_wb_illegal_nxt = r_wb_illegal;

    case (r_state)
      IDLE: begin
        w_state_nxt = IDLE;
      end
      WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // The single edge on which the ALU result ports are sampled.
          w_state_nxt      = HOLD;
          w_wb_data_nxt    = w_capture_dat;
          w_wb_rd_nxt      = r_rd;
          w_wb_is_int_nxt  = r_is_int;
          w_wb_illegal_nxt = 1'b0;
        end
      end
      HOLD: begin
        if (bus.wb_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A new op overrides the retire path above (fire implies IDLE or retiring HOLD).
    if (w_fire) begin
      w_func_nxt   = bus.issue_func;
      w_rd_nxt     = bus.issue_rd;
      w_is_int_nxt = w_is_int;
      if (w_legal) begin
        w_state_nxt = WAIT;
        w_cnt_nxt   = w_lat - 4'd1;
      end else begin
        // Illegal codes never reach an ALU unit; report them immediately.
        w_state_nxt      = HOLD;
        w_wb_data_nxt    = '0;
        w_wb_rd_nxt      = bus.issue_rd;
        w_wb_is_int_nxt  = 1'b0;
        w_wb_illegal_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_func       <= FUNC_NOP;
      r_rd         <= '0;
      r_is_int     <= 1'b0;
      r_wb_data    <= '0;
      r_wb_rd      <= '0;
      r_wb_is_int  <= 1'b0;
      r_wb_illegal <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_func       <= w_func_nxt;
      r_rd         <= w_rd_nxt;
      r_is_int     <= w_is_int_nxt;
      r_wb_data    <= w_wb_data_nxt;
      r_wb_rd      <= w_wb_rd_nxt;
      r_wb_is_int  <= w_wb_is_int_nxt;
      r_wb_illegal <= w_wb_illegal_nxt;
    end
  end

endmodule
